// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a programmable wrap point, a per-grant hold limit
// and a one-cycle timeout pulse when a grant is forcibly released.
module round_robin_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N-1:0]     req,
  input  logic             last,
  input  logic [WIDTH-1:0] max_id,
  output logic [N-1:0]     gnt,
  output logic [WIDTH-1:0] gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [WIDTH-1:0]  ptr_r, ptr_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [N-1:0]      gnt_r, gnt_s;
  logic [WIDTH-1:0]  gnt_id_r, gnt_id_s;
  logic              gnt_valid_r, gnt_valid_s;
  logic              timeout_r, timeout_s;
  logic              ready_r;

  logic [N-1:0]      elig_s;
  logic [WIDTH-1:0]  start_s;
  logic              hi_found_s, lo_found_s, sel_found_s;
  logic [WIDTH-1:0]  hi_idx_s, lo_idx_s, sel_idx_s;
  logic [N-1:0]      hi_oh_s, lo_oh_s, sel_oh_s;
  logic              cur_req_s, hold_hit_s, release_s;

  // Requesters beyond the wrap point are masked out entirely.
  always_comb begin
    elig_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (WIDTH'(i) <= max_id) begin
        elig_s[i] = req[i];
      end else begin
        elig_s[i] = 1'b0;
      end
    end
  end

  // Rotating priority scan: lowest eligible index at or above the start point
  // wins, otherwise the lowest eligible index below it (the wrapped part).
  always_comb begin
    start_s    = (ptr_r > max_id) ? {WIDTH{1'b0}} : ptr_r;
    hi_found_s = 1'b0;
    hi_idx_s   = {WIDTH{1'b0}};
    hi_oh_s    = {N{1'b0}};
    lo_found_s = 1'b0;
    lo_idx_s   = {WIDTH{1'b0}};
    lo_oh_s    = {N{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (elig_s[i] && (WIDTH'(i) >= start_s)) begin
        hi_found_s = 1'b1;
        hi_idx_s   = WIDTH'(i);
        hi_oh_s    = {N{1'b0}};
        hi_oh_s[i] = 1'b1;
      end else if (elig_s[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = WIDTH'(i);
        lo_oh_s    = {N{1'b0}};
        lo_oh_s[i] = 1'b1;
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    sel_found_s = hi_found_s | lo_found_s;
    sel_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
    sel_oh_s    = hi_found_s ? hi_oh_s  : lo_oh_s;
  end

  // Release conditions for the running grant.
  always_comb begin
    cur_req_s  = |(req & gnt_r);
    hold_hit_s = (hold_cnt_r == HOLD_LAST);
    release_s  = last | ~cur_req_s | hold_hit_s;
  end

  // Next-state and output decode.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    hold_cnt_s  = hold_cnt_r;
    gnt_s       = gnt_r;
    gnt_id_s    = gnt_id_r;
    gnt_valid_s = gnt_valid_r;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        gnt_s       = {N{1'b0}};
        gnt_valid_s = 1'b0;
        if (enable && ready_r && sel_found_s) begin
          state_s     = ST_GRANT;
          gnt_s       = sel_oh_s;
          gnt_id_s    = sel_idx_s;
          gnt_valid_s = 1'b1;
          hold_cnt_s  = {HOLD_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_s     = ST_IDLE;
          gnt_s       = {N{1'b0}};
          gnt_valid_s = 1'b0;
          hold_cnt_s  = {HOLD_W{1'b0}};
          ptr_s       = (gnt_id_r >= max_id) ? {WIDTH{1'b0}} : (gnt_id_r + WIDTH'(1));
          // Pulse only when the limit alone forced the release.
          timeout_s   = hold_hit_s & ~last & cur_req_s;
        end else begin
          hold_cnt_s = hold_cnt_r + HOLD_W'(1);
        end
      end
      default: begin
        state_s     = ST_IDLE;
        gnt_s       = {N{1'b0}};
        gnt_valid_s = 1'b0;
        hold_cnt_s  = {HOLD_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs; ready_r holds off grants for the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {WIDTH{1'b0}};
      hold_cnt_r  <= {HOLD_W{1'b0}};
      gnt_r       <= {N{1'b0}};
      gnt_id_r    <= {WIDTH{1'b0}};
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      hold_cnt_r  <= hold_cnt_s;
      gnt_r       <= gnt_s;
      gnt_id_r    <= gnt_id_s;
      gnt_valid_r <= gnt_valid_s;
      timeout_r   <= timeout_s;
      ready_r     <= 1'b1;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_id    = gnt_id_r;
  assign gnt_valid = gnt_valid_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter (N=4, WIDTH=2, MAX_HOLD=4).
module tb_round_robin_arbiter;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] req;
  logic       last;
  logic [1:0] max_id;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int total;
  int bad;

  round_robin_arbiter #(.N(4), .WIDTH(2), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req       (req),
    .last      (last),
    .max_id    (max_id),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                         input logic ev, input logic eto);
    chk({tag, ".gnt"},     {28'd0, gnt},       {28'd0, eg});
    chk({tag, ".gnt_id"},  {30'd0, gnt_id},    {30'd0, eid});
    chk({tag, ".valid"},   {31'd0, gnt_valid}, {31'd0, ev});
    chk({tag, ".timeout"}, {31'd0, timeout},   {31'd0, eto});
  endtask

  initial begin
    logic [1:0] rot_exp [5];
    logic [1:0] wrap_exp [4];
    total  = 0;
    bad    = 0;
    rot_exp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    wrap_exp = '{2'd1, 2'd0, 2'd1, 2'd0};

    rst    = 1'b1;
    enable = 1'b0;
    req    = 4'b0000;
    last   = 1'b0;
    max_id = 2'd3;
    #2 rst = 1'b0;
    tick();
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // First edge after deassertion must not grant.
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b1;
    req    = 4'b1111;
    last   = 1'b1;
    tick();
    chk_all("startup", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();

    // Rotation with last high: 0,1,2,3,0 separated by gap cycles.
    for (int k = 0; k < 5; k++) begin
      chk_all("rot.grant", 4'b0001 << rot_exp[k], rot_exp[k], 1'b1, 1'b0);
      if (k < 4) begin
        tick();
        chk_all("rot.gap", 4'b0000, rot_exp[k], 1'b0, 1'b0);
        tick();
      end
    end

    // Wrap point lowered mid-grant: alternates 1,0,1,0.
    max_id = 2'd1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all("wrap.gap", 4'b0000, wrap_exp[(k + 3) % 4], 1'b0, 1'b0);
      tick();
      chk_all("wrap.grant", 4'b0001 << wrap_exp[k], wrap_exp[k], 1'b1, 1'b0);
    end

    // Timeout on requester 2.
    req    = 4'b0100;
    last   = 1'b0;
    max_id = 2'd3;
    tick();
    chk_all("to.drop0", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_all("to.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("to.hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    tick();
    chk_all("to.pulse", 4'b0000, 2'd2, 1'b0, 1'b1);
    tick();
    chk_all("to.regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    // last coinciding with the hold limit is a normal release.
    tick();
    tick();
    tick();
    chk_all("lasthold.hold3", 4'b0100, 2'd2, 1'b1, 1'b0);
    last = 1'b1;
    tick();
    chk_all("lasthold.rel", 4'b0000, 2'd2, 1'b0, 1'b0);
    last = 1'b0;

    // Enable gating.
    enable = 1'b0;
    req    = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_all("en.off", 4'b0000, 2'd2, 1'b0, 1'b0);
    end
    enable = 1'b1;
    tick();
    chk_all("en.on", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Withdrawal of requester 3 wraps the pointer to 0.
    req  = 4'b1010;
    last = 1'b1;
    tick();
    chk_all("wd.gap", 4'b0000, 2'd1, 1'b0, 1'b0);
    last = 1'b0;
    tick();
    chk_all("wd.grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0010;
    tick();
    chk_all("wd.drop", 4'b0000, 2'd3, 1'b0, 1'b0);
    req = 4'b1111;
    tick();
    chk_all("wd.ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Move the pointer off 0, then reset mid-grant between edges.
    last = 1'b1;
    tick();
    chk_all("rs.gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    last = 1'b0;
    tick();
    chk_all("rs.grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk_all("rs.async", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_all("rs.startup", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_all("rs.grant0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Requesters above max_id are never granted.
    req    = 4'b1100;
    max_id = 2'd1;
    tick();
    chk_all("mask.drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_all("mask.idle1", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_all("mask.idle2", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
